div_sched: RTL

// - Two-requester scheduler/sequencer for one shared iterative shift-subtract divider.
// - Arbitrates round-robin, loads the core, counts iterations and returns quotient/remainder.
// - Flags divide-by-zero.
// - Sits between two client blocks and the divider datapath (sub-module div_core).

---
 rtl/div_sched_pkg.sv | 19 +
 rtl/div_sched_core.sv | 64 ++++++
 rtl/div_sched.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/div_sched_pkg.sv
// Shared types and constants for the div_sched scheduler and its divider core.
package div_sched_pkg;

   // Default operand width (also the number of divider iterations).
   localparam int DEF_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Width of the iteration counter, which must be able to hold W-1.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/div_sched_core.sv
// Restoring shift-subtract divider datapath: one quotient bit per step, no control FSM.
// The quo/rem outputs show the values the registers take at the next edge, so the
// scheduler can capture the result of the final step on the same edge that performs it.
module div_core
   import div_sched_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic         step,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] quo,
   output logic [W-1:0] rem
);

   // 2W-1 bits hold the divisor shifted up by W-1 without overflow.
   localparam int RW = 2 * W - 1;

   logic [RW-1:0] rem_q, rem_d;
   logic [RW-1:0] div_q, div_d;
   logic [W-1:0]  quo_q, quo_d;

   // Load operands, or perform one compare/subtract/shift iteration.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and a latch is never inferred.
      rem_d = rem_q;
      div_d = div_q;
      quo_d = quo_q;
      if (ld) begin
         rem_d = RW'(a);
         div_d = RW'(b) << (W - 1);
         quo_d = '0;
      end else if (step) begin
         if (rem_q >= div_q) begin
            rem_d = rem_q - div_q;
            quo_d = {quo_q[W-2:0], 1'b1};
         end else begin
            quo_d = {quo_q[W-2:0], 1'b0};
         end
         div_d = div_q >> 1;
      end
   end

   // Datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         rem_q <= '0;
         div_q <= '0;
         quo_q <= '0;
      end else begin
         rem_q <= rem_d;
         div_q <= div_d;
         quo_q <= quo_d;
      end
   end

   assign quo = quo_d;
   assign rem = rem_d[W-1:0];

endmodule

// File: rtl/div_sched.sv
// Two-requester round-robin scheduler driving one shared iterative divider.
// Accept at cycle T -> LOAD at T+1 -> RUN for W cycles -> DONE at T+W+2 (T+2 on divide-by-zero).
module div_sched
   import div_sched_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         req1_ready,
   output logic         busy,
   output logic         done,
   output logic         done_id,
   output logic [W-1:0] quot,
   output logic [W-1:0] rem,
   output logic         err
);

   localparam int CW = cnt_width(W);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d;
   logic          id_q, id_d;
   logic          last_gnt_q, last_gnt_d;
   logic [W-1:0]  quot_q, quot_d, rem_q, rem_d;
   logic          err_q, err_d, done_id_q, done_id_d;

   logic          gnt0, gnt1, acc0, acc1;
   logic          core_ld, core_step;
   logic [W-1:0]  core_quo, core_rem;

   div_core #(.W(W)) u_core (
      .clk  (clk),
      .rst  (rst),
      .ld   (core_ld),
      .step (core_step),
      .a    (a_q),
      .b    (b_q),
      .quo  (core_quo),
      .rem  (core_rem)
   );

   // Round-robin arbiter: a lone requester wins; on a tie the one not granted last wins.
   always_comb begin
      gnt0 = req0_valid & (~req1_valid | last_gnt_q);
      gnt1 = req1_valid & (~req0_valid | ~last_gnt_q);
   end

   assign req0_ready = (state_q == IDLE) & gnt0;
   assign req1_ready = (state_q == IDLE) & gnt1;
   assign acc0       = req0_valid & req0_ready;
   assign acc1       = req1_valid & req1_ready;

   // Next-state logic: operand latching, core control, iteration count, result capture.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      id_d       = id_q;
      last_gnt_d = last_gnt_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      err_d      = err_q;
      done_id_d  = done_id_q;
      core_ld    = 1'b0;
      core_step  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (acc0 | acc1) begin
               a_d        = acc1 ? req1_a : req0_a;
               b_d        = acc1 ? req1_b : req0_b;
               id_d       = acc1;
               last_gnt_d = acc1;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            core_ld = 1'b1;
            cnt_d   = CW'(W - 1);
            if (b_q == '0) begin
               quot_d    = '1;
               rem_d     = a_q;
               err_d     = 1'b1;
               done_id_d = id_q;
               state_d   = DONE;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            core_step = 1'b1;
            cnt_d     = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               quot_d    = core_quo;
               rem_d     = core_rem;
               err_d     = 1'b0;
               done_id_d = id_q;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any job in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= 1'b0;
         last_gnt_q <= 1'b1;
         quot_q     <= '0;
         rem_q      <= '0;
         err_q      <= 1'b0;
         done_id_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         id_q       <= id_d;
         last_gnt_q <= last_gnt_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         err_q      <= err_d;
         done_id_q  <= done_id_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign done_id = done_id_q;
   assign quot    = quot_q;
   assign rem     = rem_q;
   assign err     = err_q;

endmodule
